// File: rtl/mlp_stream_io.sv
// Host-side stream responder for the MLP core: loads the input buffer from
// data_in, kicks the core, then streams the output buffer back one byte per cycle.
module mlp_stream_io #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned AW        = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 ready,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic [DATA_SIZE-1:0] ofmap,
    output logic                 valid,
    output logic                 done,
    output logic                 ibuf_we,
    output logic [AW-1:0]        ibuf_addr,
    output logic [DATA_SIZE-1:0] ibuf_wdata,
    output logic                 core_start,
    output logic                 core_mode,
    input  logic                 core_done,
    output logic                 obuf_re,
    output logic [AW-1:0]        obuf_addr,
    input  logic [DATA_SIZE-1:0] obuf_rdata
);

    localparam int unsigned BCW = 8;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t                 state;
    logic [AW-1:0]          widx;
    logic [BCW-1:0]         bcnt;
    logic                   start_pend;
    logic                   rd_q;
    logic [DATA_SIZE-1:0]   sh;
    logic [DATA_SIZE-1:0]   nxt;

    logic [AW-1:0]          last_word;
    logic [BCW-1:0]         total_bytes;
    logic [1:0]             lane;
    logic [AW-1:0]          word;
    logic [DATA_SIZE-1:0]   src;
    logic [7:0]             sh_byte;

    assign last_word   = core_mode ? AW'(31) : AW'(15);
    assign total_bytes = core_mode ? BCW'(128) : BCW'(64);
    assign lane        = bcnt[1:0];
    assign word        = bcnt[6:2];
    // A freshly returned word is used directly; otherwise the prefetched copy.
    assign src         = rd_q ? obuf_rdata : nxt;
    assign sh_byte     = sh[{lane, 3'b000} +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            widx       <= '0;
            bcnt       <= '0;
            start_pend <= 1'b0;
            rd_q       <= 1'b0;
            sh         <= '0;
            nxt        <= '0;
            ofmap      <= '0;
            valid      <= 1'b0;
            done       <= 1'b0;
            ibuf_we    <= 1'b0;
            ibuf_addr  <= '0;
            ibuf_wdata <= '0;
            core_start <= 1'b0;
            core_mode  <= 1'b0;
            obuf_re    <= 1'b0;
            obuf_addr  <= '0;
        end else begin
            ibuf_we    <= 1'b0;
            ibuf_addr  <= '0;
            ibuf_wdata <= '0;
            core_start <= 1'b0;
            obuf_re    <= 1'b0;
            obuf_addr  <= '0;
            rd_q       <= obuf_re;
            if (rd_q) begin
                nxt <= obuf_rdata;
            end

            case (state)
                IDLE: begin
                    if (ready) begin
                        core_mode <= mode;
                        widx      <= '0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    ibuf_we    <= 1'b1;
                    ibuf_addr  <= widx;
                    ibuf_wdata <= data_in;
                    widx       <= widx + AW'(1);
                    if (widx == last_word) begin
                        start_pend <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    core_start <= start_pend;
                    start_pend <= 1'b0;
                    if (!start_pend && core_done) begin
                        obuf_re   <= 1'b1;
                        obuf_addr <= '0;
                        done      <= 1'b1;
                        bcnt      <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bcnt == total_bytes) begin
                        valid     <= 1'b0;
                        done      <= 1'b0;
                        ofmap     <= '0;
                        core_mode <= 1'b0;
                        state     <= IDLE;
                    end else if (bcnt != '0 || rd_q) begin
                        valid <= 1'b1;
                        bcnt  <= bcnt + BCW'(1);
                        if (lane == 2'd0) begin
                            sh    <= src;
                            ofmap <= DATA_SIZE'(src[7:0]);
                        end else begin
                            ofmap <= DATA_SIZE'(sh_byte);
                        end
                        // Prefetch the next word while byte 1 of the current one is shown.
                        if (lane == 2'd1 && word != last_word) begin
                            obuf_re   <= 1'b1;
                            obuf_addr <= word + AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_stream_io.sv
// Scoreboard bench for mlp_stream_io with a behavioural core and output buffer.
module tb_mlp_stream_io;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        ready;
    logic [31:0] data_in;
    logic [31:0] ofmap;
    logic        valid;
    logic        done;
    logic        ibuf_we;
    logic [4:0]  ibuf_addr;
    logic [31:0] ibuf_wdata;
    logic        core_start;
    logic        core_mode;
    logic        core_done;
    logic        obuf_re;
    logic [4:0]  obuf_addr;
    logic [31:0] obuf_rdata;

    logic        model_done;
    logic        inj_done;
    int          run_cnt;

    logic [31:0] mem [32];
    logic [7:0]  exp_b [$];
    logic [36:0] exp_w [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cur_n = 16;
    int n_act = 16;
    int d0 = 0;
    bit active = 0;
    int starts = 0;
    int rds = 0;
    int popped = 0;
    int last_wr = 0;
    bit last_seen = 0;
    logic exp_mode = 1'b0;

    assign core_done = model_done | inj_done;

    mlp_stream_io #(.DATA_SIZE(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .mode(mode), .ready(ready), .data_in(data_in),
        .ofmap(ofmap), .valid(valid), .done(done),
        .ibuf_we(ibuf_we), .ibuf_addr(ibuf_addr), .ibuf_wdata(ibuf_wdata),
        .core_start(core_start), .core_mode(core_mode), .core_done(core_done),
        .obuf_re(obuf_re), .obuf_addr(obuf_addr), .obuf_rdata(obuf_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Core model: completion pulse ten cycles after start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt    <= 0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (core_start) begin
                run_cnt <= 9;
            end else if (run_cnt != 0) begin
                run_cnt <= run_cnt - 1;
                if (run_cnt == 1) model_done <= 1'b1;
            end
        end
    end

    // Output buffer model: data valid only in the cycle after the read.
    always @(posedge clk or posedge rst) begin
        if (rst) obuf_rdata <= '0;
        else     obuf_rdata <= obuf_re ? mem[obuf_addr] : 32'hDEADBEEF;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ibuf_we) begin
                if (exp_w.size() == 0) begin
                    check("ibuf_extra", 64'(ibuf_we), 64'(0));
                end else begin
                    check("ibuf_write", 64'({ibuf_addr, ibuf_wdata}), 64'(exp_w.pop_front()));
                    last_wr = cyc;
                end
            end
            if (core_start) begin
                starts++;
                check("core_mode", 64'(core_mode), 64'(exp_mode));
                check("start_cycle", 64'(cyc), 64'(last_wr + 1));
            end
            if (obuf_re) begin
                check("obuf_addr", 64'(obuf_addr), 64'(rds));
                check("read_cycle", 64'(cyc), 64'(rds == 0 ? d0 : d0 + 4 * rds - 1));
                rds++;
            end
            if (valid) begin
                if (exp_b.size() == 0) begin
                    check("byte_extra", 64'(valid), 64'(0));
                end else begin
                    check("ofmap", 64'(ofmap), 64'({24'h0, exp_b.pop_front()}));
                    popped++;
                    if (exp_b.size() == 0) last_seen = 1;
                end
            end else begin
                check("ofmap_idle", 64'(ofmap), 64'(0));
            end
            if (active) begin
                check("valid_win", 64'(valid), 64'(cyc >= d0 + 2 && cyc <= d0 + 1 + 4 * n_act));
                check("done_win", 64'(done), 64'(cyc >= d0 && cyc <= d0 + 1 + 4 * n_act));
                if (cyc >= d0 + 2 + 4 * n_act) active = 0;
            end else begin
                check("quiet", 64'({valid, done}), 64'(0));
            end
            if (model_done) begin
                d0 = cyc + 1;
                n_act = cur_n;
                active = 1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_zero", 64'({ofmap, valid, done, ibuf_we, ibuf_addr, core_start,
                                 core_mode, obuf_re, obuf_addr}), 64'(0));
        check("reset_wdata", 64'(ibuf_wdata), 64'(0));
        exp_b.delete();
        exp_w.delete();
        active = 0;
        ready = 1'b0;
        inj_done = 1'b0;
        data_in = '0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_txn(input logic m, input logic [7:0] base, input bit inj,
                             input int abort_word);
        logic [31:0] w;
        cur_n = m ? 32 : 16;
        exp_mode = m;
        starts = 0;
        rds = 0;
        popped = 0;
        last_seen = 0;
        for (int k = 0; k < 32; k++) begin
            for (int l = 0; l < 4; l++) mem[k][8*l +: 8] = base + 8'(4 * k + l);
        end
        for (int k = 0; k < cur_n; k++) begin
            exp_w.push_back({5'(k), mem[k]});
            for (int l = 0; l < 4; l++) exp_b.push_back(base + 8'(4 * k + l));
        end
        @(posedge clk);
        #1 ready = 1'b1;
        mode = m;
        for (int i = 0; i < cur_n; i++) begin
            @(posedge clk);
            #1;
            w = mem[i];
            data_in = w;
            mode = ~m;
            ready = inj && (i == 3);
            inj_done = inj && (i == 5);
            if (i == abort_word) begin
                @(posedge clk);
                #1;
                do_reset();
                return;
            end
        end
        @(posedge clk);
        #1 data_in = '0;
        ready = 1'b0;
        inj_done = 1'b0;
    endtask

    task automatic finish_txn(input bit inj);
        int k = 0;
        int ph = 0;
        while (!last_seen && k < 800) begin
            @(negedge clk);
            k++;
            if (inj) begin
                if (k == 3) ready = 1'b1;
                else if (k == 4) ready = 1'b0;
                if (popped >= 10 && ph == 0) begin
                    ready = 1'b1;
                    ph = 1;
                end else if (ph == 1) begin
                    ready = 1'b0;
                    ph = 2;
                end
            end
        end
        ready = 1'b0;
        check("drain_complete", 64'(last_seen), 64'(1));
        check("writes_left", 64'(exp_w.size()), 64'(0));
        check("start_count", 64'(starts), 64'(1));
        check("read_count", 64'(rds), 64'(cur_n));
    endtask

    initial begin
        rst = 1'b1;
        mode = 1'b0;
        ready = 1'b0;
        data_in = '0;
        inj_done = 1'b0;
        repeat (3) @(negedge clk);
        check("por_zero", 64'({ofmap, valid, done, ibuf_we, ibuf_addr, core_start,
                               core_mode, obuf_re, obuf_addr}), 64'(0));
        #1 rst = 1'b0;

        start_txn(1'b0, 8'h00, 1'b0, -1);
        finish_txn(1'b0);
        repeat (3) @(negedge clk);

        start_txn(1'b1, 8'h80, 1'b0, -1);
        finish_txn(1'b0);
        repeat (3) @(negedge clk);

        start_txn(1'b0, 8'h40, 1'b1, -1);
        finish_txn(1'b1);
        repeat (3) @(negedge clk);

        start_txn(1'b1, 8'h10, 1'b0, 7);
        start_txn(1'b0, 8'h20, 1'b0, -1);
        finish_txn(1'b0);
        repeat (3) @(negedge clk);

        begin
            int k = 0;
            start_txn(1'b0, 8'h55, 1'b0, -1);
            while (popped < 21 && k < 300) begin
                @(negedge clk);
                k++;
            end
            check("mid_drain_reach", 64'(popped), 64'(21));
            #1;
            do_reset();
        end
        start_txn(1'b0, 8'h00, 1'b0, -1);
        finish_txn(1'b0);
        repeat (3) @(negedge clk);

        start_txn(1'b1, 8'hA0, 1'b0, -1);
        finish_txn(1'b0);
        start_txn(1'b0, 8'h33, 1'b0, -1);
        finish_txn(1'b0);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
